// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter
// Round-robin arbiter that shares one W-bit flip-flop register among N
// requesters. A requester holds its grant until it drops req; while it owns
// the register, its write-enabled data is clocked in. One idle GAP cycle
// separates consecutive owners.
//
// Optional feature: define ARB_TIMEOUT_EN to cap each grant at MAX_HOLD
// cycles and pulse err_timeout on a forced release. Without it, no hold
// counter is built and err_timeout is tied low.
module dff_reg_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         we,
    input  logic [N*W-1:0]       d,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic [W-1:0]         q,
    output logic                 err_timeout
);

    localparam int PW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] win_next_ptr;
    logic [N-1:0]  win_onehot;
    logic          found;
    logic          force_rel;

    // Round-robin search: first set req bit starting at ptr, wrapping modulo N.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N;
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        win_onehot   = N'(1) << win;
        win_next_ptr = (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);

    logic [CW-1:0] hold_cnt;

    // Hold counter: zero outside BUSY, so each grant starts counting from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (state != S_BUSY) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + CW'(1);
        end
    end

    assign force_rel = (state == S_BUSY) && (hold_cnt == CW'(MAX_HOLD - 1)) && req[owner];

    // err_timeout marks the GAP cycle that follows a forced release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= force_rel;
        end
    end
`else
    assign force_rel   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Arbitration FSM, grant/owner/pointer registers and the shared register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst) begin
            state <= S_IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
            q     <= '0;
        end else begin
            case (state)
                S_IDLE, S_GAP: begin
                    if (found) begin
                        state <= S_BUSY;
                        gnt   <= win_onehot;
                        owner <= win;
                        ptr   <= win_next_ptr;
                    end else begin
                        state <= S_IDLE;
                        gnt   <= '0;
                    end
                end
                S_BUSY: begin
                    // Owner's write lands even on the release edge.
                    if (we[owner]) begin
                        q <= d[owner*W +: W];
                    end
                    if (!req[owner] || force_rel) begin
                        state <= S_GAP;
                        gnt   <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign busy = |gnt;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed self-checking bench for dff_reg_arbiter (N=4, W=8, MAX_HOLD=4).
// The timeout scenario adapts to whether ARB_TIMEOUT_EN is defined.
module tb_dff_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   we;
    logic [N*W-1:0] d;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   q;
    logic           err_timeout;

    int checks = 0;
    int errors = 0;

    dff_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .we          (we),
        .d           (d),
        .gnt         (gnt),
        .owner       (owner),
        .busy        (busy),
        .q           (q),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req = 4'b0100; we = 4'b0100; d = 32'h005A_0000;
        tick(); tick();
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL reset_pre_q: got %h expected %h", q, 8'h5A); end
        checks++; if (owner !== 2'd2) begin errors++; $display("FAIL reset_pre_owner: got %0d expected %0d", owner, 2); end
        #3; rst = 1'b0; #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected %h", q, 8'h00); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected %0d", owner, 0); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected %b", err_timeout, 1'b0); end
        // Pointer was 3 before reset; after reset it must be 0, so requester 1 beats 3.
        req = 4'b1010; we = 4'b0000; rst = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL reset_ptr_gnt: got %b expected %b", gnt, 4'b0010); end
        checks++; if (owner !== 2'd1) begin errors++; $display("FAIL reset_ptr_owner: got %0d expected %0d", owner, 1); end
        req = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_single();
        req = 4'b0100; we = 4'b0100; d = 32'h00A5_0000;
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected %b", gnt, 4'b0100); end
        checks++; if (owner !== 2'd2) begin errors++; $display("FAIL single_owner: got %0d expected %0d", owner, 2); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected %b", busy, 1'b1); end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL single_q_early: got %h expected %h", q, 8'h00); end
        tick();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL single_q: got %h expected %h", q, 8'hA5); end
        req = 4'b0000; we = 4'b0000;
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_release: got %b expected %b", gnt, 4'b0000); end
        tick();
    endtask

    task automatic test_fairness();
        rst = 1'b0; #1; rst = 1'b1;
        req = 4'b1111; we = 4'b0000;
        for (int k = 0; k < N; k++) begin
            tick();
            checks++; if (gnt !== 4'(1 << k)) begin errors++; $display("FAIL fair_gnt%0d: got %b expected %b", k, gnt, 4'(1 << k)); end
            checks++; if (owner !== 2'(k)) begin errors++; $display("FAIL fair_owner%0d: got %0d expected %0d", k, owner, k); end
            tick(); tick();
            checks++; if (gnt !== 4'(1 << k)) begin errors++; $display("FAIL fair_hold%0d: got %b expected %b", k, gnt, 4'(1 << k)); end
            req[k] = 1'b0;
            tick();
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL fair_gap%0d: got %b expected %b", k, gnt, 4'b0000); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_gap_busy%0d: got %b expected %b", k, busy, 1'b0); end
            req[k] = (k != N - 1);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_nonowner_write();
        req = 4'b0010; we = 4'b0000; d = '0;
        tick();
        checks++; if (owner !== 2'd1) begin errors++; $display("FAIL nw_owner: got %0d expected %0d", owner, 1); end
        we = 4'b1000; d = 32'hFF00_0000;
        tick();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL nw_ignored: got %h expected %h", q, 8'h00); end
        we = 4'b0010; d = 32'h0000_3C00;
        tick();
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL nw_owner_write: got %h expected %h", q, 8'h3C); end
        // Write and release on the same edge: both must take effect.
        req = 4'b0000; d = 32'h0000_C300;
        tick();
        checks++; if (q !== 8'hC3) begin errors++; $display("FAIL nw_release_write_q: got %h expected %h", q, 8'hC3); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL nw_release_write_gnt: got %b expected %b", gnt, 4'b0000); end
        // In GAP the register holds regardless of we.
        we = 4'b1111; d = 32'h1111_1111;
        tick();
        checks++; if (q !== 8'hC3) begin errors++; $display("FAIL nw_gap_hold: got %h expected %h", q, 8'hC3); end
        we = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rmg_gnt: got %b expected %b", gnt, 4'b1000); end
        #3; rst = 1'b0; #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rmg_abort: got %b expected %b", gnt, 4'b0000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmg_busy: got %b expected %b", busy, 1'b0); end
        rst = 1'b1; req = 4'b1010;
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rmg_regrant: got %b expected %b", gnt, 4'b0010); end
        req = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_timeout();
        rst = 1'b0; #1; rst = 1'b1;
        req = 4'b0011; we = 4'b0000;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL to_gnt: got %b expected %b", gnt, 4'b0001); end
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c < 4; c++) begin
            tick();
            checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL to_hold%0d: got %b expected %b", c, gnt, 4'b0001); end
            checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_err_early%0d: got %b expected %b", c, err_timeout, 1'b0); end
        end
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL to_forced: got %b expected %b", gnt, 4'b0000); end
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err_pulse: got %b expected %b", err_timeout, 1'b1); end
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_next: got %b expected %b", gnt, 4'b0010); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b expected %b", err_timeout, 1'b0); end
`else
        for (int c = 1; c <= 22; c++) begin
            tick();
            checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL to_hold%0d: got %b expected %b", c, gnt, 4'b0001); end
            checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_err%0d: got %b expected %b", c, err_timeout, 1'b0); end
        end
`endif
        req = 4'b0000;
        tick(); tick();
    endtask

    initial begin
        rst = 1'b0; req = '0; we = '0; d = '0;
        #12 rst = 1'b1;
        test_reset();
        test_single();
        test_fairness();
        test_nonowner_write();
        test_reset_mid_grant();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_reg_arbiter.md
# dff_reg_arbiter

Round-robin arbiter and sequencer for a shared W-bit D-flip-flop register. It shares the register among N requesters through a req/gnt handshake. The owner holds the grant until it drops its request, and while it holds the grant its write-enabled data is clocked into the shared register. The block sits between requester logic and the flip-flop storage it controls.

## Interface
- N, 4, number of requesters (2..8)
- W, 8, shared register width
- MAX_HOLD, 16, maximum grant length in cycles (used only with ARB_TIMEOUT_EN)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req  input  N  per-requester request, level, held until done
- we  input  N  per-requester write enable
- d  input  N*W  packed write data; requester i uses d[i*W +: W]
- gnt  output  N  one-hot grant, registered
- owner  output  $clog2(N)  index of current/last owner, registered
- busy  output  1  high while in BUSY
- q  output  W  shared register contents
- err_timeout  output  1  one-cycle pulse on forced release

## Operation
- Reset (rst=0) takes effect immediately, independent of clk:
  - gnt=0, owner=0, busy=0, q=0, err_timeout=0
  - state=IDLE, round-robin pointer ptr=0, hold counter=0
- States:
  - IDLE: gnt=0. If any req, pick the winner, go to BUSY; else stay.
  - BUSY: gnt[owner]=1. Go to GAP when req[owner]=0 is sampled (or on forced release).
  - GAP: gnt=0 for exactly one cycle. If any req, pick the winner, go to BUSY; else go to IDLE.
- Pick rule:
  - Winner = first set bit of req, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
  - On grant: owner<=winner, ptr<=(winner+1) mod N.
  - The release cycle does not change ptr.
- Write path:
  - In BUSY, at each edge where we[owner]=1, q<=d[owner*W +: W].
  - we of non-owners is ignored.
  - q holds in IDLE and GAP.
  - A write and a release in the same cycle are both honoured (q updates, state goes to GAP).
- req changes from non-owners during BUSY have no effect until the next pick.
- Mid-operation reset aborts the grant with no partial state kept; ptr returns to 0.

## Timing
- Grant latency: req sampled high at edge k in IDLE/GAP, gnt high after edge k.
- Release: req[owner] sampled low at edge k, gnt low after edge k (GAP), earliest next gnt after edge k+1.
- Minimum gnt-low gap between consecutive owners: 1 cycle.
- Write latency: q reflects data one edge after the we/d cycle.
- busy equals |gnt.
- err_timeout is high only in the first GAP cycle after a forced release.

## Configuration
- ARB_TIMEOUT_EN defined:
  - The hold counter counts BUSY cycles and resets on entry to BUSY.
  - When the counter reaches MAX_HOLD-1 with req[owner] still high, that edge forces BUSY→GAP and sets err_timeout for one cycle.
  - The grant therefore lasts at most MAX_HOLD cycles.
  - The pointer has already advanced past the owner, so the next pick favours others. The same owner is regranted only if it is the sole requester.
- ARB_TIMEOUT_EN not defined:
  - No counter is built.
  - err_timeout is tied to 0.
  - The grant is held indefinitely while req[owner]=1.

## Test plan
- Reset: drive rst=0 mid-clock → gnt=0, q=8'h00, busy=0, owner=0, err_timeout=0 without waiting for an edge.
- Single requester: req=4'b0100, we[2]=1, d[23:16]=8'hA5 → gnt=4'b0100 after 1 edge, q=8'hA5 after next edge, owner=2.
- Fairness: after reset hold req=4'b1111, each owner drops its req 3 cycles after grant → grant order 0,1,2,3, gnt low exactly 1 cycle between owners.
- Non-owner write: owner=1, we=4'b1000, d[31:24]=8'hFF → q unchanged. Then we[1]=1, d[15:8]=8'h3C → q=8'h3C.
- Reset mid-grant: owner=3 in BUSY, pulse rst=0 → gnt=0 immediately. After release, req=4'b1010 → requester 1 wins (ptr=0).
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req[0] stuck high, req[1] high → gnt[0] high 4 cycles, err_timeout 1-cycle pulse in the GAP cycle, then gnt=4'b0010. Without the macro, gnt[0] stays high for 20+ cycles and err_timeout stays 0.
